// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access controller: word/byte loads, word stores, byte stores as read-modify-write.
// Latency: done in the 3rd cycle counting the req cycle (4th for byte store) with mem_ready high; per-phase timeout -> err.
// Backpressure: req ignored while busy; mem_ready stalls a phase up to TIMEOUT_CYCLES. Macro LOAD_SIGN_EXT_EN sign-extends byte loads.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        Load_Select,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] Load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state;
    logic        we_q;
    logic        ls_q;
    logic [31:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  wait_cnt;
    logic [31:0] mem_wdata_q;
    logic [31:0] load_data_q;

    logic [4:0]  byte_sh;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [31:0] rd_byte_ext;
    logic [31:0] byte_mask;
    logic [31:0] merged;

    assign byte_sh    = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_rdata >> byte_sh;
    assign rd_byte    = rd_shifted[7:0];
    assign byte_mask  = 32'h0000_00FF << byte_sh;
    assign merged     = (mem_rdata & ~byte_mask) | ({24'h000000, wdata_q} << byte_sh);

`ifdef LOAD_SIGN_EXT_EN
    assign rd_byte_ext = {{24{rd_byte[7]}}, rd_byte};
`else
    assign rd_byte_ext = {24'h000000, rd_byte};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            ls_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 8'h0;
            wait_cnt    <= 8'h0;
            mem_wdata_q <= 32'h0;
            load_data_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        ls_q     <= Load_Select;
                        addr_q   <= addr;
                        wdata_q  <= wdata[7:0];
                        wait_cnt <= 8'h0;
                        // Misaligned word access is rejected before touching memory.
                        if (!Load_Select && addr[1:0] != 2'b00) begin
                            state <= S_ERR;
                        end else if (we && !Load_Select) begin
                            mem_wdata_q <= wdata;
                            state       <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'h0;
                        if (we_q) begin
                            mem_wdata_q <= merged;
                            state       <= S_WR;
                        end else begin
                            load_data_q <= ls_q ? rd_byte_ext : mem_rdata;
                            state       <= S_DONE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        wait_cnt <= 8'h0;
                        state    <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) || (state == S_ERR);
    assign err       = (state == S_ERR);
    assign mem_req   = (state == S_RD) || (state == S_WR);
    assign mem_we    = (state == S_WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;
    assign Load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl with a word-array memory model and responder.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        Load_Select = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] Load_data, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .Load_Select(Load_Select),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .Load_data(Load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct packed { logic err; logic [31:0] ld; } exp_t;
    typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] dut_mem [int unsigned];
    logic [31:0] ref_ld = 32'h0;

    int checks = 0;
    int failures = 0;
    bit stall = 0;
    bit force_rdy = 0;
    int done_cnt = 0;
    int done_cycle = 0;
    int mreq_cycles = 0;
    int zero_run = 0;

    function automatic logic [31:0] init_word(input int unsigned wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] rd_ref(input int unsigned wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] rd_dut(input int unsigned wa);
        if (dut_mem.exists(wa)) return dut_mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] b);
`ifdef LOAD_SIGN_EXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'h000000, b};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a >> 2] = v;
        dut_mem[a >> 2] = v;
    endtask

    // Memory responder: drives mem_ready/mem_rdata shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                mem_rdata = mem_we ? $urandom : rd_dut(mem_addr >> 2);
                if (stall) mem_ready = 1'b0;
                else if (force_rdy || zero_run >= 3) mem_ready = 1'b1;
                else mem_ready = ($urandom_range(0, 2) != 0);
                if (mem_ready) zero_run = 0;
                else zero_run++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                zero_run = 0;
            end
        end
    end

    // Monitor: scoreboard pops for granted writes and for every done pulse.
    initial begin
        exp_t e;
        wr_t w;
        forever begin
            @(negedge clk);
            if (mem_req) mreq_cycles++;
            if (mem_req && mem_we && mem_ready) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
                end else begin
                    w = wr_q.pop_front();
                    check("write_addr", mem_addr, w.a);
                    check("write_data", mem_wdata, w.d);
                end
                dut_mem[mem_addr >> 2] = mem_wdata;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cycle;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done: err %b Load_data %h", err, Load_data);
                end else begin
                    e = exp_q.pop_front();
                    check("done_err", {31'h0, err}, {31'h0, e.err});
                    check("Load_data", Load_data, e.ld);
                end
            end
        end
    end

    task automatic access(input bit w, input bit l, input logic [31:0] a,
                          input logic [31:0] d, input bit st, input int exp_lat);
        int unsigned wa;
        int off;
        logic [31:0] old, nw;
        exp_t e;
        int c, n0;
        wa  = a >> 2;
        off = int'(a[1:0]);
        old = rd_ref(wa);
        e.err = 1'b0;
        if ((!l && a[1:0] != 2'b00) || st) begin
            e.err = 1'b1;
        end else if (!w) begin
            ref_ld = l ? ext8(old[8*off +: 8]) : old;
        end else begin
            nw = l ? ((old & ~(32'hFF << (8 * off))) | ({24'h0, d[7:0]} << (8 * off))) : d;
            ref_mem[wa] = nw;
            wr_q.push_back('{a: {a[31:2], 2'b00}, d: nw});
        end
        e.ld = ref_ld;
        exp_q.push_back(e);
        stall = st;
        @(posedge clk);
        #1;
        we = w; Load_Select = l; addr = a; wdata = d; req = 1'b1;
        c = cycle;
        n0 = done_cnt;
        @(posedge clk);
        #1;
        req = 1'b0;
        we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
        for (int i = 0; i < 200 && done_cnt == n0; i++) @(posedge clk);
        if (done_cnt == n0) begin
            checks++; failures++;
            $display("FAIL done_timeout: no done within 200 cycles, addr %h", a);
        end else if (exp_lat > 0) begin
            check("latency", 32'(done_cycle - c + 1), 32'(exp_lat));
        end
        stall = 0;
    endtask

    initial begin
        int m0, d0;
        bit w, l, st;
        logic [31:0] a;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_Load_data", Load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        force_rdy = 1;
        preload(32'h100, 32'hA1B2C3D4);
        access(0, 0, 32'h100, 32'h0, 0, 3);
        check("word_load_literal", Load_data, 32'hA1B2C3D4);

        preload(32'h100, 32'h80112233);
        access(0, 1, 32'h103, 32'h0, 0, 3);
`ifdef LOAD_SIGN_EXT_EN
        check("byte_load_literal", Load_data, 32'hFFFFFF80);
`else
        check("byte_load_literal", Load_data, 32'h00000080);
`endif

        preload(32'h200, 32'h11223344);
        access(1, 1, 32'h201, 32'h00000055, 0, 4);
        check("byte_store_mem", rd_dut(32'h200 >> 2), 32'h11225544);

        m0 = mreq_cycles;
        access(1, 0, 32'h102, 32'hDEADBEEF, 0, 2);
        check("misalign_no_mem_req", 32'(mreq_cycles - m0), 32'h0);

        access(0, 0, 32'h100, 32'h0, 1, 17);
        check("timeout_keeps_load", Load_data, 32'h00000080 | (Load_data & 32'hFFFFFF00));
        access(1, 0, 32'h104, 32'h0BADF00D, 1, 17);
        access(1, 0, 32'h104, 32'hCAFE1234, 0, 3);
        for (int i = 0; i < 4; i++) access(0, 1, 32'h104 + 32'(i), 32'h0, 0, 3);

        force_rdy = 0;
        for (int n = 0; n < 80; n++) begin
            w  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'($urandom_range(0, 63));
            if (!l && $urandom_range(0, 99) < 85) a[1:0] = 2'b00;
            st = ($urandom_range(0, 99) < 8);
            access(w, l, a, $urandom, st, 0);
        end

        // Reset in the middle of a stalled word store, with req raised while busy.
        stall = 1;
        @(posedge clk);
        #1;
        we = 1'b1; Load_Select = 1'b0; addr = 32'h108; wdata = 32'h12345678; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1; addr = 32'h10C; we = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wr_mem_req", {31'h0, mem_req}, 32'h1);
        check("mid_wr_mem_we", {31'h0, mem_we}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", {31'h0, mem_req}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_Load_data", Load_data, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        req = 1'b0;
        ref_ld = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        d0 = done_cnt;
        m0 = mreq_cycles;
        repeat (20) @(posedge clk);
        check("post_rst_no_done", 32'(done_cnt - d0), 32'h0);
        check("post_rst_no_access", 32'(mreq_cycles - m0), 32'h0);
        access(0, 0, 32'h108, 32'h0, 0, 0);

        repeat (3) @(posedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15, the maximum number of cycles to wait for mem_ready per memory phase (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 1 bit, CPU access request, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1 bit, 1 = store, 0 = load.
REQ-006 The block SHALL have port Load_Select, input, 1 bit, 1 = byte access, 0 = word access.
REQ-007 The block SHALL have port addr, input, 32 bits, byte address; addr[1:0] is the byte offset.
REQ-008 The block SHALL have port wdata, input, 32 bits, store data; for byte stores only wdata[7:0] is used.
REQ-009 The block SHALL have ports busy (out, 1), done (out, 1), err (out, 1) and Load_data (out, 32): controller-active flag, one-cycle completion pulse, error qualifier valid with done, and load result.
REQ-010 The block SHALL have memory-side ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32) and mem_ready (in, 1); mem_ready completes the current phase.

Function
REQ-011 States SHALL be IDLE, RD, WR, DONE and ERR, with busy = 1 in every state except IDLE.
REQ-012 In IDLE with req=1, the block SHALL register we, Load_Select, addr and wdata, then transition as follows: load → RD; word store → WR with mem_wdata = wdata; byte store → RD (read-modify-write).
REQ-013 A word access with addr[1:0] != 0 SHALL go IDLE→ERR, with no mem_req issued.
REQ-014 mem_req SHALL be 1 exactly while in RD or WR; mem_we = 1 only in WR; mem_addr = {addr_q[31:2], 2'b00}.
REQ-015 In RD with mem_ready=1: a load SHALL capture mem_rdata and go to DONE; a byte store SHALL replace byte addr_q[1:0] of mem_rdata with wdata_q[7:0], drive the result on mem_wdata and go to WR.
REQ-016 In WR with mem_ready=1, the block SHALL go to DONE.
REQ-017 Load_data SHALL be: word load → captured mem_rdata; byte load → byte selected by offset (00→[7:0], 01→[15:8], 10→[23:16], 11→[31:24]) extended to 32 bits per REQ-025.
REQ-018 Load_data SHALL update only on load completion and hold its value until the next completed load; stores and errors SHALL NOT change it.
REQ-019 DONE and ERR SHALL each last one cycle, assert done=1 (with err=1 in ERR), then return to IDLE.
REQ-020 req SHALL be ignored while busy=1; a new req is accepted at the earliest in the IDLE cycle after done.
REQ-021 An 8-bit wait counter SHALL clear on every entry to RD or WR and increment each cycle in RD or WR with mem_ready=0; when it reaches TIMEOUT_CYCLES with mem_ready still 0, the block SHALL go to ERR, and the aborted phase SHALL perform no write and cause no Load_data update.
REQ-022 mem_ready SHALL be ignored outside RD and WR.
REQ-023 Minimum latency: a load or word store with mem_ready held at 1 SHALL produce done 3 cycles after the req cycle; a byte store SHALL produce done 4 cycles after the req cycle.

Reset
REQ-024 While rst_n=0, the block SHALL immediately hold: state IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Load_data=0, wait counter 0; an access in flight SHALL be abandoned, with no done pulse after reset release.

Configuration
REQ-025 Macro LOAD_SIGN_EXT_EN: when defined, byte loads SHALL be sign-extended from bit 7 of the selected byte; when undefined, byte loads SHALL be zero-extended ({24'h000000, byte}).

Verification
REQ-026 Word load: addr=0x100, mem_rdata=0xA1B2C3D4, mem_ready=1 → mem_addr=0x100, done after 3 cycles, Load_data=0xA1B2C3D4, err=0.
REQ-027 Byte load with Load_Select=1, addr=0x103, mem_rdata=0x80112233 → Load_data=0x00000080 with the macro undefined, 0xFFFFFF80 with LOAD_SIGN_EXT_EN defined.
REQ-028 Byte store: addr=0x201, wdata=0x55, read data 0x11223344 → WR phase with mem_addr=0x200, mem_wdata=0x11225544, mem_we=1, done after 4 cycles.
REQ-029 Word store to addr=0x102 → err=1 and done=1 together, mem_req never asserted; mem_ready held 0 on a load with TIMEOUT_CYCLES=15 → ERR after 15 RD cycles, Load_data unchanged.
REQ-030 rst_n pulled low mid-WR, with a req issued while busy → mem_req drops immediately, no done pulse follows, and the ignored req causes no access.
